// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM timebase family.
// Imported by the PWM top and its prescaler.
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 10;
    localparam int DEF_PRESC_W = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Bit offset of channel ch inside the flattened duty bus.
    function automatic int duty_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: tick is high once every prescale+1 clk cycles.
// Held in its start state while disabled, so the first tick follows prescale+1 clks after enable.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    // A count beyond a freshly lowered prescale wraps to 0 without a tick.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= prescale) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign tick = enable && (presc_cnt == prescale);

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM on one shared timebase: edge/center counting, per-channel polarity,
// and duty/period/mode updates that take effect only at period boundaries.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic                    mode,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    duty_load,
    input  logic [NUM_CH-1:0]       polarity,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick,
    output logic [CNT_W-1:0]        cnt_value
);

    logic             tick;
    logic             at_end;
    logic             boundary;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic             mode_act;
    pwm_dir_e         dir;
    logic [CNT_W-1:0] duty_in  [NUM_CH];
    logic [CNT_W-1:0] duty_sh  [NUM_CH];
    logic [CNT_W-1:0] duty_act [NUM_CH];
    logic [NUM_CH-1:0] raw;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    // Center mode ends a period on the down-count step from 1 to 0; a zero period ends every tick.
    always_comb begin
        at_end = 1'b0;
        if (mode_act == PWM_MODE_EDGE) begin
            at_end = (cnt == period_act);
        end else if (period_act == '0) begin
            at_end = 1'b1;
        end else begin
            at_end = (cnt == CNT_W'(1)) && (dir == DIR_DOWN);
        end
    end

    assign boundary  = tick && at_end;
    assign cnt_value = cnt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_in[i] = duty[duty_lsb(i, CNT_W) +: CNT_W];
        assign raw[i]     = (cnt < duty_act[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            dir         <= DIR_UP;
            period_act  <= '0;
            mode_act    <= PWM_MODE_EDGE;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (duty_load) begin
                for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= duty_in[i];
            end

            if (!enable) begin
                cnt         <= '0;
                dir         <= DIR_UP;
                period_act  <= period;
                mode_act    <= mode;
                pwm_out     <= polarity;
                period_tick <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
            end else begin
                pwm_out     <= raw ^ polarity;
                period_tick <= boundary;
                // Boundary reads the pre-load shadow, so a coincident duty_load lands a period later.
                if (boundary) begin
                    cnt        <= '0;
                    dir        <= DIR_UP;
                    period_act <= period;
                    mode_act   <= mode;
                    for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
                end else if (tick) begin
                    if (mode_act == PWM_MODE_EDGE) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (dir == DIR_UP) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt + CNT_W'(1) == period_act) dir <= DIR_DOWN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized and directed bench for pwm_multichannel against a phase-based reference model.
// The model tracks position within the period rather than an up/down counter.
module tb_pwm_multichannel;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 10;
    localparam int PRESC_W = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [PRESC_W-1:0]      prescale;
    logic [CNT_W-1:0]        period;
    logic                    mode;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic                    duty_load;
    logic [NUM_CH-1:0]       polarity;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_tick;
    logic [CNT_W-1:0]        cnt_value;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int                m_presc, m_phase, m_pact, m_mact;
    int                m_dsh  [NUM_CH];
    int                m_dact [NUM_CH];
    logic [NUM_CH-1:0] m_pwm;
    logic              m_ptick;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .mode        (mode),
        .duty        (duty),
        .duty_load   (duty_load),
        .polarity    (polarity),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .cnt_value   (cnt_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Period length in ticks and counter value as functions of phase.
    function automatic int m_len();
        if (m_mact == 0) return m_pact + 1;
        if (m_pact == 0) return 1;
        return 2 * m_pact;
    endfunction

    function automatic int m_cnt();
        if (m_mact == 0 || m_phase <= m_pact) return m_phase;
        return 2 * m_pact - m_phase;
    endfunction

    function automatic bit m_bnd_next();
        return enable && (m_presc == int'(prescale)) && (m_phase == m_len() - 1);
    endfunction

    function automatic void model_step();
        bit tick;
        bit bnd;
        int c;
        if (reset) begin
            m_presc = 0; m_phase = 0; m_pact = 0; m_mact = 0;
            m_pwm = '0; m_ptick = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_dsh[i] = 0; m_dact[i] = 0;
            end
        end else begin
            if (!enable) begin
                m_presc = 0; m_phase = 0;
                m_pact = int'(period); m_mact = int'(mode);
                for (int i = 0; i < NUM_CH; i++) m_dact[i] = m_dsh[i];
                m_pwm = polarity; m_ptick = 1'b0;
            end else begin
                tick = (m_presc == int'(prescale));
                bnd  = tick && (m_phase == m_len() - 1);
                c    = m_cnt();
                for (int i = 0; i < NUM_CH; i++) m_pwm[i] = (c < m_dact[i]) ^ polarity[i];
                m_ptick = bnd;
                m_presc = (m_presc >= int'(prescale)) ? 0 : m_presc + 1;
                if (bnd) begin
                    m_phase = 0;
                    m_pact = int'(period); m_mact = int'(mode);
                    for (int i = 0; i < NUM_CH; i++) m_dact[i] = m_dsh[i];
                end else if (tick) begin
                    m_phase++;
                end
            end
            if (duty_load) begin
                for (int i = 0; i < NUM_CH; i++) m_dsh[i] = int'(duty[i*CNT_W +: CNT_W]);
            end
        end
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_tick", 32'(period_tick), 32'(m_ptick));
        check("cnt_value", 32'(cnt_value), 32'(m_cnt()));
        duty_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_duty(input int ch, input int val);
        duty[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; prescale = '0; period = 10'd9; mode = 1'b0;
        duty = '0; duty_load = 1'b0; polarity = '0;
        set_duty(0, 0); set_duty(1, 3); set_duty(2, 9); set_duty(3, 10);
        run(3);

        // Edge mode, duties 0/3/9/10 over a 10-clk period.
        reset = 1'b0; duty_load = 1'b1; step();
        run(2);
        enable = 1'b1;
        run(45);

        // Reset mid-period, then recovery at the polarity idle level.
        reset = 1'b1; polarity = 4'b0101; step();
        reset = 1'b0; run(25);
        polarity = '0; duty_load = 1'b1; run(25);

        // Center mode, prescale 1, period 8.
        mode = 1'b1; prescale = 16'd1; period = 10'd8; set_duty(0, 4);
        duty_load = 1'b1; run(80);

        // Mid-period duty change, then a load coincident with the boundary tick.
        mode = 1'b0; prescale = '0; period = 10'd9; set_duty(1, 2); duty_load = 1'b1;
        run(25);
        set_duty(1, 7); duty_load = 1'b1; run(25);
        begin
            int k = 0;
            while (!m_bnd_next() && k < 100) begin step(); k++; end
            check("boundary_wait", 32'(m_bnd_next()), 32'd1);
        end
        set_duty(1, 4); duty_load = 1'b1; run(25);

        // Disabled idle level, then an inverted run.
        enable = 1'b0; polarity = 4'b0101; run(10);
        enable = 1'b1; run(30);

        // Shrinking prescale below the running count.
        enable = 1'b0; step();
        enable = 1'b1; prescale = 16'd1000; run(501);
        prescale = 16'd3; run(24);

        // Randomized operation.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int ch = 0; ch < NUM_CH; ch++) set_duty(ch, $urandom_range(0, 14));
                duty_load = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
                period = CNT_W'($urandom_range(0, 12));
                mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) polarity = NUM_CH'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) prescale = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
